// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Central pipeline sequencer for the 5-stage MIPS core. Each cycle it decides
// whether the PC and each inter-stage buffer advances, holds or is flushed:
//   - load-use hazards insert exactly one bubble into ID/EX,
//   - a taken branch/jump in ID flushes IF/ID,
//   - a data-memory stall freezes the whole pipeline,
//   - a halt instruction drains the pipeline into a sticky halted state.
// Two saturating performance counters track stall cycles and branch flushes.
//
// Parameters
//   DRAIN_CYCLES  cycles from halt acceptance to halted_o (ID/EX, EX/MEM and
//                 MEM/WB empty out); must be >= 1
//   CNT_W         width of the performance counters
//
// Ports
//   clk_i            clock, all state updates on the rising edge
//   rst_i            asynchronous active-low reset
//   ifid_rs_i        rs field of the instruction in IF/ID
//   ifid_rt_i        rt field of the instruction in IF/ID
//   ifid_use_rt_i    IF/ID instruction reads rt as a source
//   idex_memread_i   ID/EX instruction is a load
//   idex_rt_i        destination register of the ID/EX load
//   branch_taken_i   branch/jump in ID resolved taken
//   halt_i           IF/ID holds a halt instruction
//   dmem_stall_i     data memory not ready this cycle
//   pc_write_o       PC loads the next PC
//   IF_stall_o       IF/ID holds
//   IF_flush_o       IF/ID loads zero (nop)
//   ID_flush_o       ID/EX loads a bubble
//   EX_stall_o       ID/EX holds
//   MEM_stall_o      EX/MEM and MEM/WB hold
//   halted_o         registered, pipeline drained, sticky until reset
//   stall_cycles_o   saturating count of stall cycles
//   flush_count_o    saturating count of taken-branch flushes
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             ifid_use_rt_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic             branch_taken_i,
  input  logic             halt_i,
  input  logic             dmem_stall_i,
  output logic             pc_write_o,
  output logic             IF_stall_o,
  output logic             IF_flush_o,
  output logic             ID_flush_o,
  output logic             EX_stall_o,
  output logic             MEM_stall_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o
);

  // Sequencer states
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);

  // Performance counter slots
  localparam int CNT_STALL = 0;
  localparam int CNT_FLUSH = 1;

  logic [1:0]         state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               halted_q, halted_d;

  // Raw control decisions, before reset gating
  logic pc_write_c;
  logic if_stall_c;
  logic if_flush_c;
  logic id_flush_c;
  logic ex_stall_c;
  logic mem_stall_c;

  logic [1:0]            cnt_inc;
  logic [1:0][CNT_W-1:0] cnt_val;

  // Load-use hazard: the load in ID/EX writes a register the IF/ID instruction
  // reads. r0 is never a real dependency. The rt compare only counts when the
  // instruction actually uses rt as a source (e.g. not for an I-type dest).
  logic lu;
  assign lu = idex_memread_i && (idex_rt_i != 5'd0) &&
              ((idex_rt_i == ifid_rs_i) ||
               (ifid_use_rt_i && (idex_rt_i == ifid_rt_i)));

  // ---------------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    halted_d    = halted_q;
    pc_write_c  = 1'b0;
    if_stall_c  = 1'b0;
    if_flush_c  = 1'b0;
    id_flush_c  = 1'b0;
    ex_stall_c  = 1'b0;
    mem_stall_c = 1'b0;
    cnt_inc     = 2'b00;

    case (state_q)
      ST_RUN: begin
        if (dmem_stall_i) begin
          // Whole-pipeline freeze; every other event is re-evaluated once
          // memory is ready, so nothing is lost by ignoring it here.
          if_stall_c         = 1'b1;
          ex_stall_c         = 1'b1;
          mem_stall_c        = 1'b1;
          cnt_inc[CNT_STALL] = 1'b1;
        end else if (lu) begin
          // Hold the consumer in IF/ID and push a bubble behind the load.
          // Next cycle ID/EX holds the bubble, so the hazard clears itself.
          if_stall_c         = 1'b1;
          id_flush_c         = 1'b1;
          cnt_inc[CNT_STALL] = 1'b1;
        end else if (halt_i) begin
          // Halt advances into ID/EX; nothing younger may follow it.
          if_flush_c = 1'b1;
          drain_d    = DRAIN_LOAD;
          state_d    = ST_DRAIN;
        end else if (branch_taken_i) begin
          pc_write_c         = 1'b1;
          if_flush_c         = 1'b1;
          cnt_inc[CNT_FLUSH] = 1'b1;
        end else begin
          pc_write_c = 1'b1;
        end
      end

      ST_DRAIN: begin
        // Fetch stays frozen and IF/ID stays empty while older work retires.
        // IF_flush takes precedence over any IF/ID hold, so IF_stall stays 0.
        if_flush_c = 1'b1;
        if (dmem_stall_i) begin
          ex_stall_c         = 1'b1;
          mem_stall_c        = 1'b1;
          cnt_inc[CNT_STALL] = 1'b1;
        end else begin
          drain_d = drain_q - DRAIN_ONE;
          // <= guards against a corrupted zero count draining forever
          if (drain_q <= DRAIN_ONE) begin
            state_d  = ST_HALTED;
            halted_d = 1'b1;
          end
        end
      end

      ST_HALTED: begin
        if_flush_c = 1'b1;
      end

      default: begin
        // Unreachable encoding: recover to RUN
        state_d  = ST_RUN;
        drain_d  = '0;
        halted_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_RUN;
      drain_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      halted_q <= halted_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating performance counters. Increments are only raised in RUN and
  // DRAIN, so both counters are frozen once HALTED is reached.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_perf
      logic [CNT_W-1:0] cnt_q;

      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          cnt_q <= '0;
        end else if (cnt_inc[gi] && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      assign cnt_val[gi] = cnt_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outputs. The buffers sample the controls on the same edge, so they are
  // combinational; they are forced low while reset is held so nothing in the
  // pipeline (including the PC) moves during reset.
  // ---------------------------------------------------------------------------
  assign pc_write_o     = rst_i & pc_write_c;
  assign IF_stall_o     = rst_i & if_stall_c;
  assign IF_flush_o     = rst_i & if_flush_c;
  assign ID_flush_o     = rst_i & id_flush_c;
  assign EX_stall_o     = rst_i & ex_stall_c;
  assign MEM_stall_o    = rst_i & mem_stall_c;
  assign halted_o       = halted_q;
  assign stall_cycles_o = cnt_val[CNT_STALL];
  assign flush_count_o  = cnt_val[CNT_FLUSH];

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central pipeline sequencer for the 5-stage MIPS core: decides each cycle whether the PC and each inter-stage buffer advances, holds, or is flushed. It detects load-use hazards, applies taken-branch flushes, freezes the whole pipeline on data-memory stalls, and drains the pipeline to a sticky halt. It drives the stall/flush inputs of the IF/ID, ID/EX and EX/MEM buffers and the PC write enable, and keeps two performance counters.

## Interface
- DRAIN_CYCLES, 3: cycles from halt acceptance to halted_o (ID/EX, EX/MEM and MEM/WB empty out).
- CNT_W, 16: width of the performance counters.

- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  reset, asynchronous, active-low.
- ifid_rs_i  in  5  rs field of the instruction in IF/ID.
- ifid_rt_i  in  5  rt field of the instruction in IF/ID.
- ifid_use_rt_i  in  1  IF/ID instruction reads rt as a source.
- idex_memread_i  in  1  ID/EX instruction is a load.
- idex_rt_i  in  5  destination register of the ID/EX load.
- branch_taken_i  in  1  branch/jump in ID resolved taken.
- halt_i  in  1  IF/ID holds a halt instruction.
- dmem_stall_i  in  1  data memory not ready this cycle.
- pc_write_o  out  1  PC loads the next PC.
- IF_stall_o  out  1  IF/ID holds.
- IF_flush_o  out  1  IF/ID loads zero (nop).
- ID_flush_o  out  1  ID/EX loads a bubble.
- EX_stall_o  out  1  ID/EX holds.
- MEM_stall_o  out  1  EX/MEM and MEM/WB hold.
- halted_o  out  1  registered; pipeline drained, sticky until reset.
- stall_cycles_o  out  CNT_W  stall cycles counted.
- flush_count_o  out  CNT_W  taken-branch flushes counted.

## Operation
- States: RUN, DRAIN, HALTED. The state register, drain counter and perf counters are registered. Control outputs are combinational from the state and the current inputs, because the buffers sample them on the same edge.
- Load-use hazard, LU = idex_memread_i & (idex_rt_i != 0) & ((idex_rt_i == ifid_rs_i) | (ifid_use_rt_i & idex_rt_i == ifid_rt_i)).
- RUN, priority high to low:
  - dmem_stall_i: pc_write 0, IF_stall 1, EX_stall 1, MEM_stall 1. All flushes 0. LU, halt and branch are ignored this cycle and re-evaluated once the stall ends.
  - LU: pc_write 0, IF_stall 1, ID_flush 1. Exactly one bubble is inserted per load-use pair.
  - halt_i: pc_write 0, IF_flush 1. The halt itself advances into ID/EX. Load drain counter with DRAIN_CYCLES and go to DRAIN.
  - branch_taken_i: pc_write 1, IF_flush 1.
  - Otherwise: pc_write 1, all stall/flush outputs 0.
- DRAIN: pc_write 0, IF_flush 1. Branch and LU are ignored.
  - If dmem_stall_i: EX_stall 1, MEM_stall 1 and the counter holds.
  - Otherwise the counter decrements. When it is 1 and no stall, go to HALTED.
- HALTED: pc_write 0, IF_flush 1, other outputs 0, halted_o 1. Only reset leaves this state.
- stall_cycles_o: +1 on each RUN cycle with dmem_stall_i or LU, and on each DRAIN cycle with dmem_stall_i.
- flush_count_o: +1 on each RUN cycle that takes the branch action.
- Both counters saturate at 2^CNT_W-1 and freeze in HALTED.

## Timing
- Reset (rst_i low, async): state RUN, drain counter 0, counters 0, halted_o 0. While rst_i is low, all control outputs are 0, including pc_write_o.
- After rst_i rises with idle inputs: pc_write_o 1, all other outputs 0.
- LU stall lasts exactly 1 cycle. On the next cycle idex_memread_i is 0 because of the bubble, so RUN proceeds normally.
- Branch flush affects only the edge where branch_taken_i is high, provided no higher-priority event is present.
- halted_o rises DRAIN_CYCLES + (stall cycles during DRAIN) edges after the edge that accepts halt_i.
- Simultaneous events: when IF_flush_o and IF_stall_o would both apply, IF_flush_o wins and IF_stall_o is 0.
- Reset asserted mid-DRAIN or mid-stall returns to RUN immediately.

## Test plan
- Load-use: ID/EX lw rt=5, IF/ID add rs=5 → one cycle of pc_write 0, IF_stall 1, ID_flush 1. Next cycle all 0, pc_write 1. stall_cycles_o = 1.
- LU with idex_rt_i = 0, or a match only on rt with ifid_use_rt_i = 0 → no stall.
- Taken branch on 3 consecutive non-stalled cycles → IF_flush 1 on each cycle, flush_count_o = 3.
- dmem_stall_i high for 4 cycles while branch_taken_i and LU are high → freeze outputs for 4 cycles, no flushes. Then LU acts, then branch, in that order. stall_cycles_o = 5.
- halt_i with DRAIN_CYCLES = 3 and one dmem_stall_i cycle during DRAIN → halted_o high 4 edges after acceptance. pc_write_o stays 0 from acceptance onward. Counters freeze once halted_o is high.
- Assert rst_i in DRAIN → immediate return to RUN with counters 0. After release, pc_write_o 1.
